ssb_tx_sequencer: RTL and testbench

Transmit sequencer for `ssb_modulator`: owns its `amplitude`, `ssb_freq`, `delta_phase`, `iq` and `stdby` controls. It turns a PTT-style request into a wake/ramp-up/keyed/ramp-down/sleep sequence so the H-bridge outputs never see an amplitude step. Frequency changes are held off while keyed and applied at zero amplitude. It sits between the register/PS interface and the modulator instance.

---
 rtl/ssb_tx_sequencer_pkg.sv | 30 +++
 rtl/ssb_tx_sequencer_amp_ramp.sv | 47 ++++
 rtl/ssb_tx_sequencer.sv | 101 ++++++++++
 tb/tb_ssb_tx_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssb_tx_sequencer_pkg.sv
// ssb_pkg: shared widths, sequencer state codes and IQ mode names for the SSB transmit path
package ssb_pkg;

    localparam int AMP_W   = 27;
    localparam int FREQ_W  = 18;
    localparam int PHASE_W = 14;
    localparam int IQ_W    = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAKE      = 3'd1;
    localparam state_t ST_RAMP_UP   = 3'd2;
    localparam state_t ST_ON        = 3'd3;
    localparam state_t ST_RAMP_DOWN = 3'd4;
    localparam state_t ST_TAIL      = 3'd5;

    typedef enum logic [IQ_W-1:0] {
        IQ_OFF    = 2'd0,
        IQ_I_ONLY = 2'd1,
        IQ_Q_ONLY = 2'd2,
        IQ_BOTH   = 2'd3
    } iq_mode_e;

    // States in which the amplitude slew engine is running
    function automatic logic is_ramp(input state_t s);
        return s == ST_RAMP_UP || s == ST_ON || s == ST_RAMP_DOWN;
    endfunction

endpackage

// File: rtl/ssb_tx_sequencer_amp_ramp.sv
// amp_ramp: amplitude register that slews toward a target one step per tick, clamped at the target
module amp_ramp
    import ssb_pkg::*;
#(
    parameter int RAMP_STEP = 65536,
    parameter int RAMP_DIV  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [AMP_W-1:0] target,
    output logic [AMP_W-1:0] amp,
    output logic             at_target
);

    localparam int TW = $clog2(RAMP_DIV + 1);
    localparam logic [AMP_W:0] STEP = (AMP_W + 1)'(RAMP_STEP);

    logic [TW-1:0] tick;
    logic          tick_hit;
    logic [AMP_W:0] amp_x, tgt_x, up, nxt;

    assign amp_x     = {1'b0, amp};
    assign tgt_x     = {1'b0, target};
    assign up        = amp_x + STEP;
    assign tick_hit  = tick == TW'(RAMP_DIV - 1);
    assign at_target = amp == target;

    // One extra bit of headroom so the step can never wrap before the clamp
    always_comb nxt = (amp_x < tgt_x) ? ((up > tgt_x) ? tgt_x : up)
                                      : ((amp_x >= tgt_x + STEP) ? amp_x - STEP : tgt_x);

    // Tick divider and amplitude update; restart realigns the divider without stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            amp  <= '0;
        end else if (restart) begin
            tick <= '0;
        end else if (en) begin
            tick <= tick_hit ? '0 : tick + TW'(1);
            if (tick_hit) amp <= nxt[AMP_W-1:0];
        end
    end

endmodule

// File: rtl/ssb_tx_sequencer.sv
// ssb_tx_sequencer: PTT sequencing of standby, amplitude ramps and retunes for ssb_modulator
module ssb_tx_sequencer
    import ssb_pkg::*;
#(
    parameter int WAKE_CYCLES = 1500,
    parameter int RAMP_STEP   = 65536,
    parameter int RAMP_DIV    = 16,
    parameter int TAIL_CYCLES = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_req,
    input  logic [AMP_W-1:0]   amp_target,
    input  logic [FREQ_W-1:0]  freq_in,
    input  logic               freq_load,
    input  logic [PHASE_W-1:0] dphase_in,
    input  logic [IQ_W-1:0]    iq_in,
    output logic [AMP_W-1:0]   amplitude,
    output logic [FREQ_W-1:0]  ssb_freq,
    output logic [PHASE_W-1:0] delta_phase,
    output logic [IQ_W-1:0]    iq,
    output logic               stdby,
    output logic               tx_active,
    output logic               freq_pending
);

    localparam int WAIT_MAX = (WAKE_CYCLES > TAIL_CYCLES) ? WAKE_CYCLES : TAIL_CYCLES;
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t            state, next_state;
    logic [CW-1:0]     wait_cnt;
    logic [FREQ_W-1:0] pend_freq;
    logic [AMP_W-1:0]  ramp_target;
    logic              at_target, wait_done, ramp_restart, apply_freq;

    assign wait_done    = wait_cnt == CW'((state == ST_WAKE ? WAKE_CYCLES : TAIL_CYCLES) - 1);
    assign ramp_target  = (state == ST_RAMP_UP || state == ST_ON) ? amp_target : '0;
    assign ramp_restart = next_state != state && (next_state == ST_RAMP_UP || next_state == ST_RAMP_DOWN);
    assign apply_freq   = state == ST_RAMP_DOWN && at_target;

    amp_ramp #(.RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV)) u_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (is_ramp(state)),
        .restart   (ramp_restart),
        .target    (ramp_target),
        .amp       (amplitude),
        .at_target (at_target)
    );

    // Sequencer transitions; a dropped request always wins over timers and ramps
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      next_state = tx_req ? ST_WAKE : ST_IDLE;
            ST_WAKE:      next_state = !tx_req ? ST_TAIL : (wait_done ? ST_RAMP_UP : ST_WAKE);
            ST_RAMP_UP:   next_state = !tx_req ? ST_RAMP_DOWN : (at_target ? ST_ON : ST_RAMP_UP);
            ST_ON:        next_state = (!tx_req || freq_pending) ? ST_RAMP_DOWN : ST_ON;
            ST_RAMP_DOWN: next_state = !at_target ? ST_RAMP_DOWN : (tx_req ? ST_RAMP_UP : ST_TAIL);
            ST_TAIL:      next_state = tx_req ? ST_RAMP_UP : (wait_done ? ST_IDLE : ST_TAIL);
            default:      next_state = ST_IDLE;
        endcase
    end

    // State, wake/tail counter and control outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            stdby       <= 1'b1;
            tx_active   <= 1'b0;
            iq          <= '0;
            delta_phase <= '0;
        end else begin
            state       <= next_state;
            wait_cnt    <= (next_state != state || !(state == ST_WAKE || state == ST_TAIL)) ? '0 : wait_cnt + CW'(1);
            stdby       <= next_state == ST_IDLE;
            tx_active   <= is_ramp(next_state);
            iq          <= (next_state == ST_ON) ? iq_in : IQ_OFF;
            delta_phase <= dphase_in;
        end
    end

    // Frequency goes straight through when unkeyed, otherwise waits for amplitude zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssb_freq     <= '0;
            pend_freq    <= '0;
            freq_pending <= 1'b0;
        end else if (apply_freq) begin
            ssb_freq     <= freq_load ? freq_in : (freq_pending ? pend_freq : ssb_freq);
            freq_pending <= 1'b0;
        end else if (freq_load && is_ramp(state)) begin
            pend_freq    <= freq_in;
            freq_pending <= 1'b1;
        end else if (freq_load) begin
            ssb_freq     <= freq_in;
        end
    end

endmodule

// File: tb/tb_ssb_tx_sequencer.sv
// tb_ssb_tx_sequencer: scoreboard bench with a deadline-based reference model of the TX sequence
module tb_ssb_tx_sequencer;

    localparam int WAKE = 1500;
    localparam int STEP = 65536;
    localparam int DIV  = 16;
    localparam int TAIL = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_req = 1'b0;
    logic [26:0] amp_target = 27'd65000000;
    logic [17:0] freq_in = '0;
    logic        freq_load = 1'b0;
    logic [13:0] dphase_in = '0;
    logic [1:0]  iq_in = '0;
    logic [26:0] amplitude;
    logic [17:0] ssb_freq;
    logic [13:0] delta_phase;
    logic [1:0]  iq;
    logic        stdby, tx_active, freq_pending;

    int total = 0;
    int bad = 0;
    bit iq_rand = 1'b1;
    longint amp_chk;
    int freq_chk;

    ssb_tx_sequencer #(
        .WAKE_CYCLES(WAKE), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .TAIL_CYCLES(TAIL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .amp_target(amp_target),
        .freq_in(freq_in), .freq_load(freq_load), .dphase_in(dphase_in), .iq_in(iq_in),
        .amplitude(amplitude), .ssb_freq(ssb_freq), .delta_phase(delta_phase), .iq(iq),
        .stdby(stdby), .tx_active(tx_active), .freq_pending(freq_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] amp;
        logic [17:0] freq;
        logic [13:0] dph;
        logic [1:0]  iq;
        logic        stdby;
        logic        act;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];

    typedef enum {M_IDLE, M_WAKE, M_UP, M_ON, M_DOWN, M_TAIL} mph_e;

    mph_e   ph = M_IDLE;
    longint m_amp = 0;
    int     m_freq = 0, m_pend_val = 0, cyc = 0, deadline = 0, tick_at = 0;
    bit     m_pend = 1'b0;

    function automatic longint slew(input longint a, input longint t);
        return (a < t) ? ((a + STEP > t) ? t : a + STEP) : ((a - STEP < t) ? t : a - STEP);
    endfunction

    function automatic bit keyed(input mph_e p);
        return p == M_UP || p == M_ON || p == M_DOWN;
    endfunction

    // Reference model: phases with absolute deadlines for wake/tail and ramp ticks
    always @(posedge clk) begin : model
        mph_e   nph;
        longint tgt;
        exp_t   e;
        cyc++;
        if (!rst_n) begin
            ph = M_IDLE; m_amp = 0; m_freq = 0; m_pend = 0; m_pend_val = 0;
            e = '{amp: '0, freq: '0, dph: '0, iq: '0, stdby: 1'b1, act: 1'b0, pend: 1'b0};
        end else begin
            tgt = (ph == M_UP || ph == M_ON) ? longint'(amp_target) : 0;
            nph = ph;
            case (ph)
                M_IDLE: if (tx_req) nph = M_WAKE;
                M_WAKE: if (!tx_req) nph = M_TAIL; else if (cyc == deadline) nph = M_UP;
                M_UP:   if (!tx_req) nph = M_DOWN; else if (m_amp == tgt) nph = M_ON;
                M_ON:   if (!tx_req || m_pend) nph = M_DOWN;
                M_DOWN: if (m_amp == 0) nph = tx_req ? M_UP : M_TAIL;
                M_TAIL: if (tx_req) nph = M_UP; else if (cyc == deadline) nph = M_IDLE;
                default: nph = M_IDLE;
            endcase
            if (ph == M_DOWN && m_amp == 0) begin
                if (freq_load) m_freq = int'(freq_in);
                else if (m_pend) m_freq = m_pend_val;
                m_pend = 0;
            end else if (freq_load && keyed(ph)) begin
                m_pend = 1; m_pend_val = int'(freq_in);
            end else if (freq_load) begin
                m_freq = int'(freq_in);
            end
            if (nph != ph && (nph == M_UP || nph == M_DOWN)) tick_at = cyc + DIV;
            else if (keyed(ph) && cyc == tick_at) begin
                m_amp = slew(m_amp, tgt);
                tick_at = cyc + DIV;
            end
            if (nph != ph && nph == M_WAKE) deadline = cyc + WAKE;
            if (nph != ph && nph == M_TAIL) deadline = cyc + TAIL;
            ph = nph;
            e.amp   = 27'(m_amp);
            e.freq  = 18'(m_freq);
            e.dph   = dphase_in;
            e.iq    = (ph == M_ON) ? iq_in : 2'd0;
            e.stdby = ph == M_IDLE;
            e.act   = keyed(ph);
            e.pend  = m_pend;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expectation per clock, compared just after the edge
    always @(posedge clk) begin : monitor
        exp_t e, g;
        #1;
        g = '{amplitude, ssb_freq, delta_phase, iq, stdby, tx_active, freq_pending};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL outputs @%0t: no expectation queued", $time);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                bad++;
                $display("FAIL outputs @%0t: got amp=%0d freq=%0d dph=%0d iq=%0d stdby=%0b act=%0b pend=%0b, required amp=%0d freq=%0d dph=%0d iq=%0d stdby=%0b act=%0b pend=%0b",
                         $time, g.amp, g.freq, g.dph, g.iq, g.stdby, g.act, g.pend,
                         e.amp, e.freq, e.dph, e.iq, e.stdby, e.act, e.pend);
            end
        end
    end

    // Background randomisation of pass-through inputs
    initial forever begin
        @(negedge clk);
        dphase_in = 14'($urandom);
        iq_in = iq_rand ? 2'($urandom) : 2'd3;
    end

    function automatic bit cond(input int k);
        case (k)
            0: return stdby == 1'b0;
            1: return amplitude != 0;
            2: return longint'(amplitude) == amp_chk;
            3: return stdby == 1'b1;
            4: return amplitude == 0;
            5: return freq_pending == 1'b1;
            6: return int'(ssb_freq) == freq_chk;
            default: return tx_active == 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int k, input int exp_n, input int limit, input string name);
        int n = 0;
        while (!cond(k) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!cond(k)) begin
            bad++;
            $display("FAIL %s: not reached within %0d clocks", name, limit);
        end else if (exp_n >= 0 && n != exp_n) begin
            bad++;
            $display("FAIL %s: took %0d clocks, required %0d", name, n, exp_n);
        end
    endtask

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_amp", amplitude, 0);
        check("reset_stdby", stdby, 1);
        check("reset_freq", ssb_freq, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full keying from standby to 65000000
        tx_req = 1'b1;
        wait_cond(0, 1, 10, "stdby_fall");
        wait_cond(1, WAKE + DIV, 3000, "first_step");
        amp_chk = 65000000;
        wait_cond(2, 991 * DIV, 20000, "ramp_up_full");
        repeat (20) @(negedge clk);

        // Slew down while keyed
        amp_target = 27'd32500000;
        amp_chk = 32500000;
        wait_cond(2, -1, 9000, "slew_down");

        // Retune while keyed
        @(negedge clk);
        freq_in = 18'd178176;
        freq_load = 1'b1;
        wait_cond(5, 1, 4, "pending_set");
        freq_load = 1'b0;
        wait_cond(4, -1, 9000, "retune_down");
        freq_chk = 178176;
        wait_cond(6, 1, 4, "retune_apply");
        wait_cond(2, 496 * DIV, 9000, "retune_up");

        // Two loads while keyed: the later one wins
        @(negedge clk);
        freq_in = 18'd100000;
        freq_load = 1'b1;
        @(negedge clk);
        freq_in = 18'd120000;
        @(negedge clk);
        freq_load = 1'b0;
        wait_cond(4, -1, 9000, "double_down");
        freq_chk = 120000;
        wait_cond(6, 1, 4, "double_apply");

        // Drop request part way up the ramp, then tail with an unkeyed load
        iq_rand = 1'b0;
        amp_chk = 1048576;
        wait_cond(2, 16 * DIV, 400, "partial_up");
        tx_req = 1'b0;
        wait_cond(4, 16 * DIV + 1, 400, "partial_down");
        repeat (10) @(posedge clk);
        @(negedge clk);
        freq_in = 18'd150000;
        freq_load = 1'b1;
        freq_chk = 150000;
        wait_cond(6, 1, 4, "tail_load");
        freq_load = 1'b0;
        wait_cond(3, TAIL - 10, 200, "tail_len");

        // Asynchronous reset while keyed
        iq_rand = 1'b1;
        amp_target = 27'd200000;
        @(negedge clk);
        tx_req = 1'b1;
        wait_cond(0, 1, 10, "stdby_fall2");
        amp_chk = 200000;
        wait_cond(2, WAKE + 4 * DIV, 2000, "small_ramp");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_amp", amplitude, 0);
        check("arst_freq", ssb_freq, 0);
        check("arst_dph", delta_phase, 0);
        check("arst_iq", iq, 0);
        check("arst_stdby", stdby, 1);
        check("arst_active", tx_active, 0);
        check("arst_pend", freq_pending, 0);
        tx_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_hold_stdby", stdby, 1);
        check("idle_hold_active", tx_active, 0);

        // Randomised keying, retargeting and loads
        amp_target = 27'd300000;
        tx_req = 1'b1;
        wait_cond(7, WAKE + 1, 2000, "rand_start");
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            tx_req = $urandom_range(0, 3) != 0;
            amp_target = ($urandom_range(0, 6) == 0) ? 27'd0 : 27'($urandom_range(0, 400000));
            freq_in = 18'($urandom);
            freq_load = $urandom_range(0, 3) == 0;
            @(negedge clk);
            freq_load = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
